// File: rtl/reg_if_router_if.sv
// reg_if_router_if -- bundle of the upstream register port (from axi_lite_slave)
// and the four-client downstream register port served by reg_if_router.
//   slave  : router view (takes i_* signals, drives o_* signals)
//   master : environment view (upstream slave + client cores)
// Upstream : i_reg_address, i_reg_in_rdy/i_reg_in_data (write level request),
//            i_reg_out_req (read level request), o_reg_in_ack_stb,
//            o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr.
// Clients  : o_cli_address, o_cli_in_data, o_cli_in_rdy[3:0], o_cli_out_req[3:0],
//            i_cli_in_ack_stb[3:0], i_cli_out_rdy_stb[3:0],
//            i_cli_out_data[127:0] (client k at [32k+31:32k]), i_cli_invalid_addr[3:0].
interface reg_if_router_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] i_reg_address;
  logic                  o_reg_invalid_addr;
  logic                  i_reg_in_rdy;
  logic                  o_reg_in_ack_stb;
  logic [31:0]           i_reg_in_data;
  logic                  i_reg_out_req;
  logic                  o_reg_out_rdy_stb;
  logic [31:0]           o_reg_out_data;

  logic [ADDR_WIDTH-1:0] o_cli_address;
  logic [31:0]           o_cli_in_data;
  logic [3:0]            o_cli_in_rdy;
  logic [3:0]            i_cli_in_ack_stb;
  logic [3:0]            o_cli_out_req;
  logic [3:0]            i_cli_out_rdy_stb;
  logic [127:0]          i_cli_out_data;
  logic [3:0]            i_cli_invalid_addr;

  modport slave (
    input  i_reg_address, i_reg_in_rdy, i_reg_in_data, i_reg_out_req,
    input  i_cli_in_ack_stb, i_cli_out_rdy_stb, i_cli_out_data, i_cli_invalid_addr,
    output o_reg_invalid_addr, o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data,
    output o_cli_address, o_cli_in_data, o_cli_in_rdy, o_cli_out_req
  );

  modport master (
    output i_reg_address, i_reg_in_rdy, i_reg_in_data, i_reg_out_req,
    output i_cli_in_ack_stb, i_cli_out_rdy_stb, i_cli_out_data, i_cli_invalid_addr,
    input  o_reg_invalid_addr, o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data,
    input  o_cli_address, o_cli_in_data, o_cli_in_rdy, o_cli_out_req
  );
endinterface

// File: rtl/reg_if_router.sv
// reg_if_router -- routes one upstream register port to up to four client
// register banks selected by address[SEL_LSB+1:SEL_LSB]. One transaction at a
// time; disabled windows (and, optionally, silent clients) get a synthesized
// invalid-address response.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : reg_if_router_if.slave (upstream + client signals)
// Parameters: ADDR_WIDTH, SEL_LSB, CLIENT_EN (per-client enable mask),
//   TIMEOUT_CYCLES (2..65535, only used with the timeout build).
// Build option: define REG_IF_ROUTER_TIMEOUT_EN to compile in the client
//   response timeout; without it the wait states wait indefinitely.
// All outputs come straight from flops.
module reg_if_router #(
  parameter int         ADDR_WIDTH     = 16,
  parameter int         SEL_LSB        = 12,
  parameter logic [3:0] CLIENT_EN      = 4'b1111,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           rst,
  reg_if_router_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_WAIT = 3'd1,
    RD_WAIT = 3'd2,
    RESP    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  // Clears the select field so each client sees its own zero-based map.
  localparam logic [ADDR_WIDTH-1:0] SEL_MASK = ~(ADDR_WIDTH'(2'b11) << SEL_LSB);

  state_t                state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic [1:0]            start_sel;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            cli_wr_q, cli_wr_d;
  logic [3:0]            cli_rd_q, cli_rd_d;
  logic                  ack_q, ack_d;
  logic                  rdy_q, rdy_d;
  logic                  inv_q, inv_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  timeout_hit;

  assign start_sel = bus.i_reg_address[SEL_LSB +: 2];

`ifdef REG_IF_ROUTER_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  // Runs only while waiting on a client; any other state parks it at 0,
  // so every wait starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst)
      tmo_cnt_q <= '0;
    else if (state_q == WR_WAIT || state_q == RD_WAIT)
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    else
      tmo_cnt_q <= '0;
  end

  assign timeout_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state / next-output logic. Strobes and the error flag default low,
  // so they only rise for the single RESP cycle.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cli_wr_d = cli_wr_q;
    cli_rd_d = cli_rd_q;
    ack_d    = 1'b0;
    rdy_d    = 1'b0;
    inv_d    = 1'b0;
    rdata_d  = rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.i_reg_in_rdy || bus.i_reg_out_req) begin
          sel_d  = start_sel;
          addr_d = bus.i_reg_address & SEL_MASK;
          if (bus.i_reg_in_rdy)
            wdata_d = bus.i_reg_in_data;
          if (!CLIENT_EN[start_sel]) begin
            // Disabled window: answer immediately, never touch a client.
            state_d = RESP;
            inv_d   = 1'b1;
            if (bus.i_reg_in_rdy) begin
              ack_d = 1'b1;
            end else begin
              rdy_d   = 1'b1;
              rdata_d = 32'h0;
            end
          end else if (bus.i_reg_in_rdy) begin
            // Write wins over a simultaneous read; the read is picked up
            // after HOLD since the upstream keeps its level request.
            state_d  = WR_WAIT;
            cli_wr_d = 4'b0001 << start_sel;
          end else begin
            state_d  = RD_WAIT;
            cli_rd_d = 4'b0001 << start_sel;
          end
        end
      end

      WR_WAIT: begin
        // Client strobe is checked first so a strobe on the expiry cycle wins.
        if (bus.i_cli_in_ack_stb[sel_q]) begin
          state_d  = RESP;
          cli_wr_d = 4'b0000;
          ack_d    = 1'b1;
          inv_d    = bus.i_cli_invalid_addr[sel_q];
        end else if (timeout_hit) begin
          state_d  = RESP;
          cli_wr_d = 4'b0000;
          ack_d    = 1'b1;
          inv_d    = 1'b1;
        end
      end

      RD_WAIT: begin
        if (bus.i_cli_out_rdy_stb[sel_q]) begin
          state_d  = RESP;
          cli_rd_d = 4'b0000;
          rdy_d    = 1'b1;
          inv_d    = bus.i_cli_invalid_addr[sel_q];
          rdata_d  = bus.i_cli_out_data[32*sel_q +: 32];
        end else if (timeout_hit) begin
          state_d  = RESP;
          cli_rd_d = 4'b0000;
          rdy_d    = 1'b1;
          inv_d    = 1'b1;
          rdata_d  = 32'h0;
        end
      end

      RESP:    state_d = HOLD;
      HOLD:    state_d = IDLE;   // gives upstream a cycle to drop its request
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cli_wr_q <= '0;
      cli_rd_q <= '0;
      ack_q    <= 1'b0;
      rdy_q    <= 1'b0;
      inv_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cli_wr_q <= cli_wr_d;
      cli_rd_q <= cli_rd_d;
      ack_q    <= ack_d;
      rdy_q    <= rdy_d;
      inv_q    <= inv_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.o_reg_in_ack_stb   = ack_q;
  assign bus.o_reg_out_rdy_stb  = rdy_q;
  assign bus.o_reg_invalid_addr = inv_q;
  assign bus.o_reg_out_data     = rdata_q;
  assign bus.o_cli_address      = addr_q;
  assign bus.o_cli_in_data      = wdata_q;
  assign bus.o_cli_in_rdy       = cli_wr_q;
  assign bus.o_cli_out_req      = cli_rd_q;

endmodule

// File: doc/reg_if_router.md
# reg_if_router

Routes the simple register interface produced by `axi_lite_slave` to up to four downstream register-bank clients, selected by address window. It sits between one `axi_lite_slave` and several peripheral cores, so one AXI-Lite port can serve several register maps. It sequences one transaction at a time, returns client data and status upstream, and synthesizes an invalid-address response for disabled windows or unresponsive clients.

## Interface
- `ADDR_WIDTH`, 16, register address width.
- `SEL_LSB`, 12, LSB of the 2-bit client-select field `address[SEL_LSB+1:SEL_LSB]`.
- `CLIENT_EN`, 4'b1111, per-client enable mask; a disabled client's window returns invalid.
- `TIMEOUT_CYCLES`, 256, client response timeout in clock cycles; legal range 2..65535.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `i_reg_address` in ADDR_WIDTH: upstream register address.
- `o_reg_invalid_addr` out 1: error flag, valid with upstream strobes.
- `i_reg_in_rdy` in 1: upstream write request (level).
- `o_reg_in_ack_stb` out 1: write-complete strobe.
- `i_reg_in_data` in 32: write data.
- `i_reg_out_req` in 1: upstream read request (level).
- `o_reg_out_rdy_stb` out 1: read-complete strobe.
- `o_reg_out_data` out 32: read data.
- `o_cli_address` out ADDR_WIDTH: address to the clients, with the select field zeroed.
- `o_cli_in_data` out 32: write data, shared by all clients.
- `o_cli_in_rdy` out 4: one-hot client write request.
- `i_cli_in_ack_stb` in 4: client write-done strobes.
- `o_cli_out_req` out 4: one-hot client read request.
- `i_cli_out_rdy_stb` in 4: client read-done strobes.
- `i_cli_out_data` in 128: client read data; client k occupies bits [32k+31:32k].
- `i_cli_invalid_addr` in 4: client error flags, valid with that client's strobe.

## Operation
- FSM states:
  - IDLE
  - WR_WAIT
  - RD_WAIT
  - RESP
  - HOLD
- IDLE behaviour:
  - If `i_reg_in_rdy` is high, start a write; a write has priority over `i_reg_out_req` in the same cycle.
  - Otherwise, if `i_reg_out_req` is high, start a read.
  - At start, latch the select index k, the masked address and the write data.
- Disabled window: if `CLIENT_EN[k]`=0, go straight to RESP with invalid=1 and read data 0. No client request is asserted.
- Enabled window, write: go to WR_WAIT and hold `o_cli_in_rdy[k]`=1 until `i_cli_in_ack_stb[k]`.
- Enabled window, read: go to RD_WAIT and hold `o_cli_out_req[k]`=1 until `i_cli_out_rdy_stb[k]`.
- Client strobe received:
  - Drop the client request.
  - Capture `i_cli_invalid_addr[k]`; for reads, also capture the client's read data.
  - Go to RESP.
- Strobes from non-selected clients, and strobes arriving in IDLE, RESP or HOLD, are ignored.
- RESP lasts one cycle:
  - Pulse `o_reg_in_ack_stb` or `o_reg_out_rdy_stb`.
  - Drive `o_reg_invalid_addr` and `o_reg_out_data` for that cycle.
  - Go to HOLD.
- HOLD lasts one cycle, with requests ignored; then IDLE. This lets the upstream drop its level request.
- `o_reg_out_data` is held until the next read's RESP. `o_reg_invalid_addr` is 1 only in RESP.

## Timing
- All outputs are registered.
- Reset values: every output is 0, the FSM is in IDLE and the timeout counter is 0.
- Request latency: request sampled in IDLE at cycle N → client request high at N+1.
- Client strobe at cycle M → upstream strobe at M+1.
- Disabled window: request at N → upstream strobe at N+1.
- Back-to-back: a new request is accepted no earlier than 2 cycles after an upstream strobe (strobe cycle + HOLD).
- Timeout counter:
  - Cleared on entry to WR_WAIT/RD_WAIT and increments every cycle in those states.
  - When it reaches `TIMEOUT_CYCLES`-1 without a strobe, drop the client request and go to RESP with invalid=1; read data is 32'h0.
- Strobe arriving on the expiry cycle: the client response wins; the transaction is not flagged as a timeout.
- Reset mid-transaction: the client request drops the cycle after `rst` is sampled. No upstream strobe is issued.

## Configuration
- `REG_IF_ROUTER_TIMEOUT_EN` defined: the timeout counter and timeout path are compiled in, as above.
- `REG_IF_ROUTER_TIMEOUT_EN` not defined: the counter is removed and the WAIT states wait indefinitely for the client strobe. `TIMEOUT_CYCLES` is ignored.

## Test plan
- Write to client 1:
  - Stimulus: `i_reg_address`=16'h1008, data 32'hCAFE0001; client 1 acks 2 cycles after rdy.
  - Required: `o_cli_in_rdy`=4'b0010, `o_cli_address`=16'h0008, `o_cli_in_data`=32'hCAFE0001.
  - Required: one `o_reg_in_ack_stb` pulse with invalid=0, the cycle after the ack.
- Read from client 2:
  - Stimulus: address 16'h2004; client 2 returns 32'h12345678 with its strobe.
  - Required: `o_reg_out_data`=32'h12345678 and a single `o_reg_out_rdy_stb` pulse; `o_cli_out_req` drops the cycle after the strobe.
- Disabled window:
  - Stimulus: `CLIENT_EN`=4'b0111, read 16'h3000.
  - Required: no client request; strobe at N+1 with invalid=1 and data 0.
- Simultaneous write and read:
  - Stimulus: `i_reg_in_rdy` and `i_reg_out_req` both high in IDLE.
  - Required: the write completes first; the read is served after HOLD.
- Timeout (with `REG_IF_ROUTER_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16):
  - Stimulus: client 0 never strobes.
  - Required: the request drops after 16 cycles; upstream strobe with invalid=1.
  - Stimulus: a late strobe from client 0.
  - Required: it is ignored.
- Reset mid-read:
  - Stimulus: assert `rst` during RD_WAIT.
  - Required: all outputs are 0 the next cycle, with no strobe; a following read completes normally.
